shift_exec_stage: RTL
=====================

Name: shift_exec_stage

Overview:
Two-stage pipelined execute wrapper for the 16-bit barrel shifter in the RISC datapath. It accepts a shift micro-op from decode over a valid/ready handshake and registers the operands. It drives an internal instance of bar_shift_lr_16b (ports a, sel, lr, b) and registers the result with a destination tag and status flags for writeback. It supports full-rate throughput, backpressure and flush.

Parameters:
TAG_W, 3, width of the destination-register tag carried alongside each op.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush, active high
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept an op this cycle
in_op  input  2  00 pass-through, 01 logical left, 10 logical right, 11 arithmetic right
in_a  input  16  operand to shift
in_shamt  input  4  shift amount 0..15
in_tag  input  TAG_W  destination tag
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_res  output  16  shifted result
out_tag  output  TAG_W  tag of the result
out_c  output  1  carry: last bit shifted out
out_z  output  1  result equals zero
out_n  output  1  result bit 15

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Pipeline registers:
  - S1 holds s1_valid, op, a, shamt and tag.
  - S2 holds out_valid, out_res, out_tag and the flags.
- Reset (rst_n low, asynchronous):
  - s1_valid=0, out_valid=0, out_res=0, out_tag=0, out_c=0, out_z=0, out_n=0.
  - in_ready reads 1 after reset release.
- Advance and accept logic:
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !flush & (!s1_valid | s2_free). This is combinational from out_ready, with no skid buffer.
  - Accept = in_valid & in_ready. On accept, S1 loads the inputs and s1_valid=1. Otherwise, if s1_adv, s1_valid=0.
- S1 to S2 transfer: on s1_adv, S2 loads the S1 contents and out_valid=1. Otherwise, if out_ready, out_valid=0. When out_valid=1 and out_ready=0, S2 holds all outputs stable.
- Latency and throughput: latency is 2 clk edges from accept to out_valid. Throughput is 1 op per cycle while out_ready=1.
- Datapath from S1 (combinational, feeds the S2 register):
  - The shifter takes sel=shamt and lr=op.
  - Result = shifter b for op 01, 10 and 11. For op 00 the result is operand a (bypass); shifter output is ignored.
- Carry, with k=shamt:
  - op 01, k>0: C = a[16-k].
  - op 10 or 11, k>0: C = a[k-1].
  - k=0 or op 00: C = 0.
- Zero and negative flags: Z = (result==16'h0), N = result[15].
- Flush, sampled at the clock edge:
  - s1_valid=0 and out_valid=0. Data registers may retain their old contents.
  - in_ready=0 during the flush cycle, so no op is accepted even if in_valid=1.
  - Flush has priority over a simultaneous accept, advance and out_ready.
- Simultaneous events: accept and s1_adv in the same cycle is legal (S1 refills while S2 loads). out_ready with no s1_adv drains S2 to empty.
- Reset mid-operation: in-flight ops are discarded with no partial output. out_valid drops in the same cycle rst_n falls.

Optional Feature:
SHIFT_FLAGS_EN
- Defined: out_c, out_z and out_n are computed and registered as above.
- Undefined: the flag logic and flag registers are not built, and out_c, out_z and out_n are tied to 0. Result, tag and handshake timing are unchanged.

Test Plan:
- in_a=16'hA5A5, op=01, shamt=3, tag=5, out_ready=1 -> 2 edges later: out_valid=1, out_res=16'h2D28, out_tag=5, C=1, Z=0, N=0.
- in_a=16'hA5A5, op=10 shamt=4, then op=11 shamt=4 on back-to-back cycles -> consecutive results 16'h0A5A (C=0, N=0), then 16'hFA5A (C=0, N=1), with no bubble.
- in_a=16'h8000, op=01, shamt=1 -> out_res=16'h0000, Z=1, C=1. Then in_a=16'hA5A5, op=00, shamt=7 -> out_res=16'hA5A5, C=0.
- Backpressure: out_ready=0, issue 3 ops -> first held in S2 and second in S1; in_ready=0 and third stalled with in_valid held. Raise out_ready -> all 3 emerge in order, one per cycle.
- Flush with S1 and S2 valid and in_valid=1 -> next cycle out_valid=0, s1_valid=0, and the presented op is not accepted. It is accepted on the following cycle and arrives 2 edges later.
- Drive rst_n low asynchronously, mid-clock, with both stages valid -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1.

Source files
------------

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage pipelined execute wrapper around the 16-bit
// barrel shifter (bar_shift_lr_16b). S1 registers the decoded shift micro-op,
// S2 registers the shifted result, destination tag and status flags.
// Valid/ready handshake on both sides, full-rate throughput, synchronous flush.
//
// Optional feature macro: SHIFT_FLAGS_EN
//   defined   -> carry/zero/negative flags are computed and registered
//   undefined -> flag logic is not built; out_c/out_z/out_n are tied to 0

// 16-bit barrel shifter: lr selects pass (00), logical left (01),
// logical right (10) or arithmetic right (11) by sel bit positions.
module bar_shift_lr_16b (
  input  logic [15:0] a,
  input  logic [3:0]  sel,
  input  logic [1:0]  lr,
  output logic [15:0] b
);

  // Select the shift direction/kind; default assignment keeps this latch-free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    b = a;
    case (lr)
      2'b01:   b = a << sel;
      2'b10:   b = a >> sel;
      2'b11:   b = 16'($signed(a) >>> sel);
      default: b = a;
    endcase
  end

endmodule

module shift_exec_stage #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [15:0]      in_a,
  input  logic [3:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n
);

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_SLL  = 2'b01,
    OP_SRL  = 2'b10,
    OP_SRA  = 2'b11
  } op_e;

  // S1 pipeline register contents
  logic             s1_valid;
  op_e              s1_op;
  logic [15:0]      s1_a;
  logic [3:0]       s1_shamt;
  logic [TAG_W-1:0] s1_tag;

  // Handshake / advance controls
  logic s2_free;
  logic s1_adv;
  logic accept;

  // Datapath between S1 and S2
  logic [15:0] shift_b;
  logic [15:0] res_d;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  // in_ready is combinational from out_ready: there is no skid buffer, so S1
  // can only take a new op if it is empty or draining into S2 this cycle.
  assign in_ready = !flush && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  bar_shift_lr_16b u_shift (
    .a   (s1_a),
    .sel (s1_shamt),
    .lr  (s1_op),
    .b   (shift_b)
  );

  // Pass-through bypasses the shifter output entirely.
  assign res_d = (s1_op == OP_PASS) ? s1_a : shift_b;

  // S1 occupancy: flush wins, then accept (refill), then drain into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S1 operand capture on accept.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; s1_valid alone qualifies them, so stale data is harmless.
    if (accept) begin
      s1_op    <= op_e'(in_op);
      s1_a     <= in_a;
      s1_shamt <= in_shamt;
      s1_tag   <= in_tag;
    end
  end

  // S2 result register: loads on advance, holds while stalled, empties when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= 16'h0000;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_res   <= res_d;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic [16:0] left_ext;
  logic [16:0] right_ext;
  logic        carry_d;

  // Carry is the last bit shifted out; widening by one bit makes k=0 yield 0.
  always_comb begin
    left_ext  = {1'b0, s1_a} << s1_shamt;
    right_ext = {s1_a, 1'b0} >> s1_shamt;
    carry_d   = 1'b0;
    case (s1_op)
      OP_SLL:         carry_d = left_ext[16];
      OP_SRL, OP_SRA: carry_d = right_ext[0];
      default:        carry_d = 1'b0;
    endcase
  end

  // Flag registers track the S2 result register load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_c <= 1'b0;
      out_z <= 1'b0;
      out_n <= 1'b0;
    end else if (!flush && s1_adv) begin
      out_c <= carry_d;
      out_z <= (res_d == 16'h0000);
      out_n <= res_d[15];
    end
  end
`else
  assign out_c = 1'b0;
  assign out_z = 1'b0;
  assign out_n = 1'b0;
`endif

endmodule
